// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronises board reset and PLL lock, releases domain resets in order,
// and re-asserts them on runtime requests. Optional cause register behind `RST_CAUSE_EN`.
module rst_seq_ctrl #(
  parameter int NUM_DOM     = 3,
  parameter int POR_CYCLES  = 16,
  parameter int STEP_CYCLES = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               arst_n_i,
  input  logic               pll_lock_i,
  input  logic               sw_rst_i,
  input  logic               wdt_rst_i,
  output logic [NUM_DOM-1:0] rst_o,
  output logic               rst_done_o
`ifdef RST_CAUSE_EN
  ,
  output logic [1:0]         rst_cause_o
`endif
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  localparam logic [1:0] CAUSE_LOCK = 2'b00;
  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [2:0] {
    S_RST, S_LOCK, S_POR, S_REL, S_RUN, S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] rst_q, rst_d;
  logic               done_q, done_d;
  logic [1:0]         rsync_q;
  logic [1:0]         lsync_q;
  logic               int_rst;
  logic               lock_sync;
  logic               enter_hold;
  logic               cause_sw;

  assign int_rst   = rsync_q[1];
  assign lock_sync = lsync_q[1];

  // Reset-release and lock synchronisers
  always_ff @(posedge clk or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rsync_q <= 2'b11;
      lsync_q <= 2'b00;
    end else begin
      rsync_q <= {rsync_q[0], 1'b0};
      lsync_q <= {lsync_q[0], pll_lock_i};
    end
  end

  always_ff @(posedge clk or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_d      = rst_q;
    done_d     = done_q;
    enter_hold = 1'b0;
    cause_sw   = 1'b0;
    case (state_q)
      S_RST: begin
        if (!int_rst) state_d = S_LOCK;
      end
      S_LOCK: begin
        if (lock_sync) begin
          state_d = S_POR;
          cnt_d   = '0;
        end
      end
      S_POR: begin
        if (wdt_rst_i || !lock_sync) begin
          enter_hold = 1'b1;
        end else if (cnt_q == CNT_W'(POR_CYCLES - 1)) begin
          state_d = S_REL;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REL: begin
        if (wdt_rst_i || !lock_sync) begin
          enter_hold = 1'b1;
        end else if (cnt_q == CNT_W'(STEP_CYCLES - 1)) begin
          rst_d[idx_q] = 1'b0;
          if (idx_q == IDX_W'(NUM_DOM - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (wdt_rst_i || sw_rst_i || !lock_sync) begin
          enter_hold = 1'b1;
          cause_sw   = sw_rst_i;
        end
      end
      S_HOLD: begin
        // Counter saturates so a long watchdog hold cannot wrap it
        if (cnt_q >= CNT_W'(HOLD_CYCLES - 1)) begin
          if (!wdt_rst_i) begin
            state_d = S_LOCK;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RST;
    endcase
    if (enter_hold) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
    end
  end

`ifdef RST_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (enter_hold) begin
      if (wdt_rst_i)     cause_d = CAUSE_WDT;
      else if (cause_sw) cause_d = CAUSE_SW;
      else               cause_d = CAUSE_LOCK;
    end
  end

  always_ff @(posedge clk or negedge arst_n_i) begin
    if (!arst_n_i) cause_q <= CAUSE_POR;
    else           cause_q <= cause_d;
  end

  assign rst_cause_o = cause_q;
`endif

  assign rst_o      = rst_q;
  assign rst_done_o = done_q;

endmodule
